// File: rtl/aes_req_arbiter.sv
// Round-robin front end that time-shares a single AES-128 core among NUM_REQ requesters.
// One transaction in flight: grant -> RUN (core busy) -> RESP (hand back result) -> CLEAR.

// Per-requester slice: window test for the round-robin scan and AND-gated payload
// contribution to the shared OR-mux.
module aes_req_arbiter_slot #(
  parameter int ID_W = 2,
  parameter int IDX  = 0
) (
  input  logic            valid,
  input  logic [ID_W-1:0] rr_ptr,
  input  logic            gnt,
  input  logic [127:0]    data,
  input  logic [127:0]    key,
  input  logic [2:0]      seed,
  output logic            upper,
  output logic [127:0]    data_sel,
  output logic [127:0]    key_sel,
  output logic [2:0]      seed_sel
);
  localparam logic [ID_W-1:0] IDX_L = ID_W'(IDX);

  // Requesters at or after the pointer win ties before the wrap-around.
  assign upper    = valid && (IDX_L >= rr_ptr);
  assign data_sel = data & {128{gnt}};
  assign key_sel  = key  & {128{gnt}};
  assign seed_sel = seed & {3{gnt}};
endmodule

module aes_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 31
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*128-1:0] req_data,
  input  logic [NUM_REQ*128-1:0] req_key,
  input  logic [NUM_REQ*3-1:0]   req_seed,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [127:0]           resp_data,
  output logic [ID_W-1:0]        resp_id,
  output logic                   core_start,
  output logic [127:0]           core_data_in,
  output logic [127:0]           core_key,
  output logic [2:0]             core_seed,
  input  logic [127:0]           core_data_out,
  input  logic                   core_done,
  output logic                   busy,
  output logic                   timeout_err
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RUN, RESP, CLEAR} state_t;

  state_t                     state, state_next;
  logic [ID_W-1:0]            rr_ptr, rr_next, gnt_id;
  logic [CNT_W-1:0]           wd_cnt;
  logic [NUM_REQ-1:0]         upper, pick, gnt;
  logic                       found, wd_fire, any_req;
  logic [NUM_REQ-1:0][127:0]  data_sel, key_sel;
  logic [NUM_REQ-1:0][2:0]    seed_sel;
  logic [127:0]               data_mux, key_mux;
  logic [2:0]                 seed_mux;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    aes_req_arbiter_slot #(.ID_W(ID_W), .IDX(i)) u_slot (
      .valid    (req_valid[i]),
      .rr_ptr   (rr_ptr),
      .gnt      (gnt[i]),
      .data     (req_data[128*i +: 128]),
      .key      (req_key[128*i +: 128]),
      .seed     (req_seed[3*i +: 3]),
      .upper    (upper[i]),
      .data_sel (data_sel[i]),
      .key_sel  (key_sel[i]),
      .seed_sel (seed_sel[i])
    );
  end

  assign any_req = |req_valid;

  // Lowest index in the upper window, else lowest overall: first valid from rr_ptr mod NUM_REQ.
  always_comb begin
    pick   = (|upper) ? upper : req_valid;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i] && !found) begin
        gnt[i] = 1'b1;
        gnt_id = ID_W'(i);
        found  = 1'b1;
      end
    end
  end

  assign rr_next = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

  always_comb begin
    data_mux = '0;
    key_mux  = '0;
    seed_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      data_mux |= data_sel[i];
      key_mux  |= key_sel[i];
      seed_mux |= seed_sel[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    wd_fire    = 1'b0;
    case (state)
      IDLE:  if (any_req) state_next = RUN;
      RUN: begin
        // A completion on the final watchdog cycle still counts as success.
        if (core_done) state_next = RESP;
        else if (wd_cnt == WD_LAST) begin
          wd_fire    = 1'b1;
          state_next = CLEAR;
        end
      end
      RESP:  if (resp_ready) state_next = CLEAR;
      CLEAR: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr       <= '0;
      wd_cnt       <= '0;
      core_data_in <= '0;
      core_key     <= '0;
      core_seed    <= '0;
      resp_data    <= '0;
      resp_id      <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          core_data_in <= data_mux;
          core_key     <= key_mux;
          core_seed    <= seed_mux;
          resp_id      <= gnt_id;
          rr_ptr       <= rr_next;
          wd_cnt       <= '0;
        end
        RUN: begin
          wd_cnt <= wd_cnt + CNT_W'(1);
          if (core_done) resp_data <= core_data_out;
        end
        default: ;
      endcase
    end
  end

  // Reset gates req_ready: state already reads IDLE while rst is low.
  assign req_ready   = gnt & {NUM_REQ{rst && (state == IDLE)}};
  assign core_start  = (state == RUN);
  assign resp_valid  = (state == RESP);
  assign busy        = (state != IDLE);
  assign timeout_err = wd_fire;
endmodule

// File: tb/tb_aes_req_arbiter.sv
// Directed bench for aes_req_arbiter: per-transaction vector table driven against a
// behavioural core model with programmable latency, plus a mid-RUN reset sequence.
module tb_aes_req_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 31;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]     req_valid = '0;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*128-1:0] req_data = '0;
  logic [NUM_REQ*128-1:0] req_key = '0;
  logic [NUM_REQ*3-1:0]   req_seed = '0;
  logic                   resp_valid;
  logic                   resp_ready = 1'b0;
  logic [127:0]           resp_data;
  logic [ID_W-1:0]        resp_id;
  logic                   core_start;
  logic [127:0]           core_data_in, core_key, core_data_out;
  logic [2:0]             core_seed;
  logic                   core_done;
  logic                   busy, timeout_err;

  aes_req_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_key(req_key), .req_seed(req_seed),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id),
    .core_start(core_start), .core_data_in(core_data_in), .core_key(core_key),
    .core_seed(core_seed), .core_data_out(core_data_out), .core_done(core_done),
    .busy(busy), .timeout_err(timeout_err)
  );

  // Core stand-in: known-answer for the FIPS-197 vector, otherwise a cheap mixing function.
  function automatic logic [127:0] model(input logic [127:0] d, input logic [127:0] k,
                                         input logic [2:0] s);
    if (d == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return d ^ {k[63:0], k[127:64]} ^ {125'd0, s};
  endfunction

  int lat  = 1;
  bit hang = 1'b0;
  int rcnt = 0;
  always @(posedge clk) begin
    if (!core_start) rcnt <= 0;
    else             rcnt <= rcnt + 1;
  end
  assign core_done     = core_start && !hang && (rcnt == lat - 1);
  assign core_data_out = model(core_data_in, core_key, core_seed);

  logic [127:0] pd [NUM_REQ];
  logic [127:0] pk [NUM_REQ];
  logic [2:0]   ps [NUM_REQ];

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    nvec++;
    if (act !== want) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  typedef struct {
    bit          rst_first;
    logic [3:0]  valid;
    int          lat;
    bit          hang;
    int          rdelay;
    int          gnt;
    bit          to;
  } vec_t;

  vec_t vecs [14];

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '1;
    #1;
    chk("rst_req_ready", 128'(req_ready), 128'd0);
    chk("rst_resp", {119'd0, resp_valid, busy, timeout_err, core_start, core_seed, resp_id}, 128'd0);
    chk("rst_resp_data", resp_data, 128'd0);
    chk("rst_core_data", core_data_in, 128'd0);
    chk("rst_core_key", core_key, 128'd0);
    @(negedge clk);
    req_valid = '0;
    rst       = 1'b1;
  endtask

  // Entered and left at a negedge, so back-to-back calls leave no idle posedge between them.
  task automatic do_vec(input vec_t v, input int idx);
    int k, t_seen, r_seen, bad;
    bit to_any;
    logic [127:0] ed;
    req_valid  = v.valid;
    lat        = v.lat;
    hang       = v.hang;
    resp_ready = (v.rdelay == 0);
    #1;
    k = 0;
    while (req_ready == '0 && k < 40) begin
      @(negedge clk); #1;
      k++;
    end
    chk($sformatf("v%0d_grant", idx), 128'(req_ready), 128'd1 << v.gnt);
    if (req_ready == '0) return;
    ed = model(pd[v.gnt], pk[v.gnt], ps[v.gnt]);
    @(posedge clk); #1;
    chk($sformatf("v%0d_run", idx), {126'd0, core_start, |req_ready}, 128'd2);
    chk($sformatf("v%0d_core_data", idx), core_data_in, pd[v.gnt]);
    chk($sformatf("v%0d_core_key", idx), core_key, pk[v.gnt]);
    chk($sformatf("v%0d_core_seed", idx), 128'(core_seed), 128'(ps[v.gnt]));
    t_seen = 0; r_seen = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (timeout_err) begin t_seen = c; break; end
      if (resp_valid)  begin r_seen = c; break; end
    end
    if (v.to) begin
      chk($sformatf("v%0d_timeout_cycle", idx), 128'(t_seen), 128'(TIMEOUT));
      @(negedge clk);
      chk($sformatf("v%0d_clear", idx),
          {124'd0, resp_valid, busy, core_start, timeout_err}, 128'b0100);
      @(negedge clk);
      chk($sformatf("v%0d_idle", idx), {126'd0, busy, resp_valid}, 128'd0);
    end else begin
      chk($sformatf("v%0d_resp_cycle", idx), 128'(r_seen), 128'(v.lat + 1));
      chk($sformatf("v%0d_resp_data", idx), resp_data, ed);
      chk($sformatf("v%0d_resp_id", idx), 128'(resp_id), 128'(v.gnt));
      bad = 0;
      to_any = 1'b0;
      for (int j = 0; j < v.rdelay; j++) begin
        @(negedge clk);
        if (resp_valid !== 1'b1 || resp_data !== ed || resp_id !== ID_W'(v.gnt) ||
            req_ready !== '0 || core_start !== 1'b0) bad++;
      end
      if (v.rdelay > 0) begin
        chk($sformatf("v%0d_hold", idx), 128'(bad), 128'd0);
        resp_ready = 1'b1;
      end
      @(negedge clk);
      to_any = timeout_err;
      chk($sformatf("v%0d_clear", idx),
          {124'd0, resp_valid, busy, core_start, to_any}, 128'b0100);
      @(negedge clk);
      chk($sformatf("v%0d_idle", idx), {126'd0, busy, resp_valid}, 128'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vec_t mr;
    for (int i = 0; i < NUM_REQ; i++) begin
      pd[i] = {4{32'hA5000000 + 32'(i * 32'h01010101)}};
      pk[i] = {4{32'h0F1E2D3C ^ 32'(i * 32'h11111111)}};
      ps[i] = 3'(i + 3);
    end
    pd[2] = FIPS_PT;
    pk[2] = FIPS_KEY;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_data[128*i +: 128] = pd[i];
      req_key[128*i +: 128]  = pk[i];
      req_seed[3*i +: 3]     = ps[i];
    end

    //          rst  valid    lat hang rdly gnt to
    vecs[0]  = '{1'b1, 4'b0100, 5,  1'b0, 0,  2, 1'b0};  // FIPS-197 from requester 2
    vecs[1]  = '{1'b1, 4'b1111, 3,  1'b0, 0,  0, 1'b0};  // round-robin from reset
    vecs[2]  = '{1'b0, 4'b1111, 4,  1'b0, 0,  1, 1'b0};
    vecs[3]  = '{1'b0, 4'b1111, 2,  1'b0, 0,  2, 1'b0};
    vecs[4]  = '{1'b0, 4'b1111, 6,  1'b0, 0,  3, 1'b0};
    vecs[5]  = '{1'b0, 4'b1111, 1,  1'b0, 0,  0, 1'b0};
    vecs[6]  = '{1'b0, 4'b0010, 3,  1'b0, 0,  1, 1'b0};
    vecs[7]  = '{1'b0, 4'b0010, 3,  1'b0, 0,  1, 1'b0};  // wraps past 2,3,0
    vecs[8]  = '{1'b0, 4'b1000, 4,  1'b0, 20, 3, 1'b0};  // backpressure
    vecs[9]  = '{1'b0, 4'b0001, 0,  1'b1, 0,  0, 1'b1};  // hung core
    vecs[10] = '{1'b0, 4'b0001, 2,  1'b0, 0,  0, 1'b0};  // served after abort
    vecs[11] = '{1'b0, 4'b0100, 31, 1'b0, 0,  2, 1'b0};  // done on watchdog cycle
    vecs[12] = '{1'b0, 4'b0011, 1,  1'b0, 0,  0, 1'b0};  // ptr=3 wraps to 0
    vecs[13] = '{1'b0, 4'b0011, 2,  1'b0, 0,  1, 1'b0};

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].rst_first) do_reset();
      do_vec(vecs[i], i);
    end

    // Reset during RUN cycle 5, then confirm the pointer restarted at 0.
    req_valid  = 4'b0001;
    lat        = 20;
    hang       = 1'b0;
    resp_ready = 1'b1;
    #1;
    chk("mr_grant", 128'(req_ready), 128'd1);
    @(posedge clk);
    repeat (5) @(negedge clk);
    chk("mr_in_run", {126'd0, core_start, resp_valid}, 128'd2);
    rst       = 1'b0;
    req_valid = '0;
    #1;
    chk("mr_ctrl", {120'd0, req_ready, resp_valid, busy, timeout_err, core_start}, 128'd0);
    chk("mr_core_data", core_data_in, 128'd0);
    chk("mr_core_key", {125'd0, core_seed} | core_key, 128'd0);
    chk("mr_resp", {126'd0, resp_id} | resp_data, 128'd0);
    @(negedge clk);
    rst = 1'b1;
    mr = '{1'b0, 4'b1111, 3, 1'b0, 0, 0, 1'b0};
    do_vec(mr, 14);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
